label_overlay_reader: RTL and testbench

Display-side consumer of the 320x240 3-bit label memory. Maps 640x480 VGA raster coordinates to half-resolution label addresses, reads each label with a registered one-cycle read, and blends a per-class palette colour over the camera pixel for display. Optionally accumulates a per-frame label histogram for the road-control logic. Sits between the VGA timing/frame-buffer path and the VGA output port, on the read clock domain of the label memory.

---
 rtl/label_pkg.sv | 62 ++++++
 rtl/label_hist.sv | 115 +++++++++++
 rtl/label_overlay_reader.sv | 207 ++++++++++++++++++++
 tb/tb_label_overlay_reader.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/label_pkg.sv
// -----------------------------------------------------------------------------
// label_pkg
//
// Shared types and constants for the label overlay display path.
//   label_t       3-bit class label stored in the 320x240 label memory
//   rgb444_t      4:4:4 RGB pixel, one 4-bit field per channel
//   hist_state_t  histogram FSM states (WAIT_FRAME, ACCUM)
//   DEF_*         default geometry / width parameters
//   palette_color per-class overlay colour lookup
//   blend_pixel   50/50 blend of a camera pixel with a palette colour
//
// The histogram feature is enabled by defining LABEL_HIST_EN; the package
// itself is identical in both builds.
// -----------------------------------------------------------------------------
package label_pkg;

    localparam int DEF_IMG_W  = 320;
    localparam int DEF_IMG_H  = 240;
    localparam int DEF_ADDR_W = 17;
    localparam int DEF_CNT_W  = 17;

    localparam int LABEL_W    = 3;
    localparam int NUM_LABELS = 1 << LABEL_W;

    typedef logic [LABEL_W-1:0] label_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [0:0] {
        WAIT_FRAME = 1'b0,
        ACCUM      = 1'b1
    } hist_state_t;

    // Class colours. Label 0 means "no class" and is never blended.
    function automatic rgb444_t palette_color(input label_t lbl);
        case (lbl)
            3'd1:    palette_color = rgb444_t'(12'hF00); // road
            3'd2:    palette_color = rgb444_t'(12'hFF0); // lane
            3'd3:    palette_color = rgb444_t'(12'h00F); // vehicle
            3'd4:    palette_color = rgb444_t'(12'h0F0); // person
            3'd5:    palette_color = rgb444_t'(12'hF0F); // sign
            3'd6:    palette_color = rgb444_t'(12'h0FF); // sky
            3'd7:    palette_color = rgb444_t'(12'hFFF); // other
            default: palette_color = rgb444_t'(12'h000); // unused
        endcase
    endfunction

    // Half camera + half palette per channel; each half is at most 7, so the
    // 4-bit sum can never wrap.
    function automatic rgb444_t blend_pixel(input rgb444_t cam, input rgb444_t pal);
        rgb444_t res;
        res.r = (cam.r >> 1) + (pal.r >> 1);
        res.g = (cam.g >> 1) + (pal.g >> 1);
        res.b = (cam.b >> 1) + (pal.b >> 1);
        return res;
    endfunction

endpackage : label_pkg

// File: rtl/label_hist.sv
// -----------------------------------------------------------------------------
// label_hist
//
// Per-frame label histogram. Counts one label per 2x2 raster block (the
// "sample" pixel) and snapshots all bins on every rising edge of vsync.
// Only built when LABEL_HIST_EN is defined.
//
// Ports:
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   vsync_i     raw frame sync; a rising edge closes the current frame
//   count_en_i  stage-2 pixel is valid and is the sample pixel of its block
//   label_i     stage-2 label (already forced to 0 for invalid pixels)
//   sel_i       bin select for cnt_o
//   cnt_o       snapshot count of bin sel_i (combinational mux)
//   valid_o     one-cycle pulse when a new snapshot has been latched
//
// The first vsync edge after reset only arms the counters: whatever frame was
// in flight when reset was released is incomplete and is discarded.
// -----------------------------------------------------------------------------
module label_hist
    import label_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync_i,
    input  logic             count_en_i,
    input  label_t           label_i,
    input  label_t           sel_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             valid_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hist_state_t      state_q, state_d;
    logic             vsync_q;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q  [NUM_LABELS];
    logic [CNT_W-1:0] cnt_d  [NUM_LABELS];
    logic [CNT_W-1:0] snap_q [NUM_LABELS];
    logic [CNT_W-1:0] snap_d [NUM_LABELS];
    logic             vs_rise_w;

    assign vs_rise_w = vsync_i & ~vsync_q;

    // NOTE: every always_comb output is given a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        snap_d  = snap_q;

        case (state_q)
            WAIT_FRAME: begin
                if (vs_rise_w) begin
                    for (int i = 0; i < NUM_LABELS; i++) begin
                        cnt_d[i] = '0;
                    end
                    state_d = ACCUM;
                end
            end

            ACCUM: begin
                if (vs_rise_w) begin
                    snap_d  = cnt_q;
                    valid_d = 1'b1;
                    for (int i = 0; i < NUM_LABELS; i++) begin
                        cnt_d[i] = '0;
                    end
                end
                // A sample landing on the edge cycle is the first pixel of the
                // new frame, so its bin restarts at 1 instead of 0.
                if (count_en_i) begin
                    if (vs_rise_w) begin
                        cnt_d[label_i] = CNT_W'(1);
                    end else if (cnt_q[label_i] != CNT_MAX) begin
                        cnt_d[label_i] = cnt_q[label_i] + 1'b1;
                    end
                end
            end

            default: state_d = WAIT_FRAME;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: the counter and snapshot arrays are flops, not RAM, and are reset
    // because hist_cnt must read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_FRAME;
            vsync_q <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < NUM_LABELS; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            vsync_q <= vsync_i;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
        end
    end

    assign cnt_o   = snap_q[sel_i];
    assign valid_o = valid_q;

endmodule : label_hist

// File: rtl/label_overlay_reader.sv
// -----------------------------------------------------------------------------
// label_overlay_reader
//
// Display-side reader of the 320x240 label memory. Each 640x480 raster pixel
// is mapped to its half-resolution label address, the label is fetched with a
// registered one-cycle memory read, and a per-class palette colour is blended
// over the camera pixel.
//
// Pipeline (one pixel per clock, 3 cycles input -> output):
//   stage 1  address generation, oe/r_addr registered
//   stage 2  memory returns read_data, sideband delayed alongside
//   stage 3  blend and output registers (overlay_en sampled here)
//
// Ports:
//   clk, rst_n       pixel clock / asynchronous active-low reset
//   de_i, x_i, y_i   display enable and raster coordinates
//   vsync_i          frame sync, active-high
//   rgb_i            camera pixel, 4:4:4
//   overlay_en       1 = blend labels, 0 = pass camera pixel through
//   oe, r_addr       label memory read enable / address
//   read_data        label memory data, valid one cycle after oe
//   de_o, vsync_o    display enable / vsync delayed by 3 cycles
//   rgb_o            display pixel
//   hist_sel         histogram bin select        (LABEL_HIST_EN only)
//   hist_cnt         latched count of that bin   (LABEL_HIST_EN only)
//   hist_valid       new-snapshot pulse          (LABEL_HIST_EN only)
//
// Build option: define LABEL_HIST_EN to add the per-frame label histogram.
// -----------------------------------------------------------------------------
module label_overlay_reader
    import label_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              de_i,
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    input  logic              vsync_i,
    input  logic [11:0]       rgb_i,
    input  logic              overlay_en,
    output logic              oe,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [2:0]        read_data,
    output logic              de_o,
    output logic              vsync_o,
    output logic [11:0]       rgb_o
`ifdef LABEL_HIST_EN
    ,
    input  logic [2:0]        hist_sel,
    output logic [CNT_W-1:0]  hist_cnt,
    output logic              hist_valid
`endif
);

    // ---------------------------------------------------------------------
    // Stage 1: address generation
    // ---------------------------------------------------------------------
    logic              pix_valid_w;
    logic [ADDR_W-1:0] ys_w;
    logic [ADDR_W-1:0] xs_w;
    logic [ADDR_W-1:0] addr_w;

    logic              oe_q,     oe_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic              s1_de_q;
    logic              s1_vs_q;
    rgb444_t           s1_rgb_q;
    logic              s1_valid_q;

    assign pix_valid_w = de_i && (x_i < 10'(2 * IMG_W)) && (y_i < 10'(2 * IMG_H));
    assign ys_w        = ADDR_W'(y_i[9:1]);
    assign xs_w        = ADDR_W'(x_i[9:1]);
    // ys*320 as shift-add (256 + 64); tied to the 320-wide label image.
    assign addr_w      = (ys_w << 8) + (ys_w << 6) + xs_w;

    // The address is held through blanking so the memory sees a stable bus.
    always_comb begin
        oe_d     = pix_valid_w;
        r_addr_d = r_addr_q;
        if (pix_valid_w) begin
            r_addr_d = addr_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_q       <= 1'b0;
            r_addr_q   <= '0;
            s1_de_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_rgb_q   <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            oe_q       <= oe_d;
            r_addr_q   <= r_addr_d;
            s1_de_q    <= de_i;
            s1_vs_q    <= vsync_i;
            s1_rgb_q   <= rgb444_t'(rgb_i);
            s1_valid_q <= pix_valid_w;
        end
    end

    assign oe     = oe_q;
    assign r_addr = r_addr_q;

    // ---------------------------------------------------------------------
    // Stage 2: sideband waits for the registered memory read
    // ---------------------------------------------------------------------
    logic    s2_de_q;
    logic    s2_vs_q;
    rgb444_t s2_rgb_q;
    logic    s2_valid_q;
    label_t  label_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_de_q    <= 1'b0;
            s2_vs_q    <= 1'b0;
            s2_rgb_q   <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s2_de_q    <= s1_de_q;
            s2_vs_q    <= s1_vs_q;
            s2_rgb_q   <= s1_rgb_q;
            s2_valid_q <= s1_valid_q;
        end
    end

    // read_data is stale for pixels that issued no read; treat them as
    // "no class" so they neither blend nor count.
    assign label_w = s2_valid_q ? label_t'(read_data) : '0;

    // ---------------------------------------------------------------------
    // Stage 3: blend and output registers
    // ---------------------------------------------------------------------
    logic    de_q;
    logic    vsync_q;
    rgb444_t rgb_q, rgb_d;

    always_comb begin
        rgb_d = s2_rgb_q;
        if (!s2_de_q) begin
            rgb_d = '0;
        end else if ((label_w != '0) && overlay_en) begin
            rgb_d = blend_pixel(s2_rgb_q, palette_color(label_w));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q    <= 1'b0;
            vsync_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            de_q    <= s2_de_q;
            vsync_q <= s2_vs_q;
            rgb_q   <= rgb_d;
        end
    end

    assign de_o    = de_q;
    assign vsync_o = vsync_q;
    assign rgb_o   = rgb_q;

    // ---------------------------------------------------------------------
    // Optional label histogram
    // ---------------------------------------------------------------------
`ifdef LABEL_HIST_EN
    // Sample flag marks the top-left pixel of each 2x2 block so every label
    // address is counted exactly once per frame.
    logic s1_samp_q;
    logic s2_samp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_samp_q <= 1'b0;
            s2_samp_q <= 1'b0;
        end else begin
            s1_samp_q <= ~x_i[0] & ~y_i[0];
            s2_samp_q <= s1_samp_q;
        end
    end

    label_hist #(
        .CNT_W (CNT_W)
    ) u_hist (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync_i    (vsync_i),
        .count_en_i (s2_valid_q & s2_samp_q),
        .label_i    (label_w),
        .sel_i      (label_t'(hist_sel)),
        .cnt_o      (hist_cnt),
        .valid_o    (hist_valid)
    );
`else
    // Without the histogram the counter width has no consumer.
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule : label_overlay_reader

// File: tb/tb_label_overlay_reader.sv
// -----------------------------------------------------------------------------
// tb_label_overlay_reader
//
// Bench for label_overlay_reader. The bench plays the label memory (registered
// one-cycle read) and keeps a pixel-level model: the expected display pixel is
// computed from the raster coordinates, the memory contents and the palette
// with plain arithmetic, and compared every cycle. Directed vectors with
// literal expectations pin the model. Histogram checks run when LABEL_HIST_EN
// is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_label_overlay_reader;

    localparam int ADDR_W = 17;
    localparam int CNT_W  = 17;
    localparam int MEM_N  = 76800;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              de_i = 1'b0;
    logic [9:0]        x_i = '0;
    logic [9:0]        y_i = '0;
    logic              vsync_i = 1'b0;
    logic [11:0]       rgb_i = '0;
    logic              overlay_en = 1'b0;
    logic              oe;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        read_data = '0;
    logic              de_o;
    logic              vsync_o;
    logic [11:0]       rgb_o;
`ifdef LABEL_HIST_EN
    logic [2:0]        hist_sel = '0;
    logic [CNT_W-1:0]  hist_cnt;
    logic              hist_valid;
    int                hv_count = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]  mem [MEM_N];
    logic [11:0] palette [8] = '{12'h000, 12'hF00, 12'hFF0, 12'h00F,
                                 12'h0F0, 12'hF0F, 12'h0FF, 12'hFFF};

    label_overlay_reader #(
        .IMG_W  (320),
        .IMG_H  (240),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .de_i       (de_i),
        .x_i        (x_i),
        .y_i        (y_i),
        .vsync_i    (vsync_i),
        .rgb_i      (rgb_i),
        .overlay_en (overlay_en),
        .oe         (oe),
        .r_addr     (r_addr),
        .read_data  (read_data),
        .de_o       (de_o),
        .vsync_o    (vsync_o),
        .rgb_o      (rgb_o)
`ifdef LABEL_HIST_EN
        ,
        .hist_sel   (hist_sel),
        .hist_cnt   (hist_cnt),
        .hist_valid (hist_valid)
`endif
    );

    always #5 clk = ~clk;

    // Label memory: registered read, data one cycle after oe.
    always @(posedge clk) begin
        if (oe === 1'b1) read_data <= mem[r_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: what the screen must show for one raster pixel
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic        rst;
        logic        de;
        logic        vs;
        logic        ov;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } rec_t;

    rec_t rec [4];
    int   cyc = 0;

    always @(posedge clk) begin
        rec[cyc % 4] <= '{rst: rst_n, de: de_i, vs: vsync_i, ov: overlay_en,
                          x: x_i, y: y_i, rgb: rgb_i};
        cyc <= cyc + 1;
    end

    function automatic logic [11:0] model_pixel(input rec_t r, input logic ov);
        logic [2:0]  lab;
        logic [11:0] pal;
        logic [11:0] res;
        if (!r.de) return 12'h000;
        if (r.x >= 640 || r.y >= 480) return r.rgb;
        lab = mem[(int'(r.y) / 2) * 320 + int'(r.x) / 2];
        if (lab == 3'd0 || !ov) return r.rgb;
        pal = palette[lab];
        for (int c = 0; c < 3; c++) begin
            res[c*4 +: 4] = r.rgb[c*4 +: 4] / 2 + pal[c*4 +: 4] / 2;
        end
        return res;
    endfunction

    // Output at this negedge belongs to the pixel sampled three edges back,
    // blended with overlay_en as sampled on the latest edge.
    task automatic compare_cycle();
        rec_t        pix;
        rec_t        mid;
        rec_t        now;
        logic        live;
        logic        exp_de;
        logic        exp_vs;
        logic        exp_oe;
        logic [11:0] exp_rgb;
        pix  = rec[(cyc - 3) % 4];
        mid  = rec[(cyc - 2) % 4];
        now  = rec[(cyc - 1) % 4];
        live = rst_n && pix.rst && mid.rst && now.rst;
        exp_de  = live ? pix.de : 1'b0;
        exp_vs  = live ? pix.vs : 1'b0;
        exp_rgb = live ? model_pixel(pix, now.ov) : 12'h000;
        check("model de_o", 32'(de_o), 32'(exp_de));
        check("model vsync_o", 32'(vsync_o), 32'(exp_vs));
        check("model rgb_o", 32'(rgb_o), 32'(exp_rgb));
        exp_oe = rst_n && now.rst && now.de && (now.x < 640) && (now.y < 480);
        check("model oe", 32'(oe), 32'(exp_oe));
        if (exp_oe) begin
            check("model r_addr", 32'(r_addr), (int'(now.y) / 2) * 320 + int'(now.x) / 2);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 3) compare_cycle();
    end

`ifdef LABEL_HIST_EN
    always @(negedge clk) begin
        if (hist_valid === 1'b1) hv_count <= hv_count + 1;
    end
`endif

    // ---------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 ns after the rising edge
    // ---------------------------------------------------------------------
    task automatic step(input logic de, input int x, input int y,
                        input logic [11:0] rgb, input logic vs);
        de_i    = de;
        x_i     = 10'(x);
        y_i     = 10'(y);
        rgb_i   = rgb;
        vsync_i = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 12'h000, 1'b0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef LABEL_HIST_EN
        int hv_before;
        int sum;
`endif
        for (int a = 0; a < MEM_N; a++) mem[a] = 3'(a % 8);
        mem[1605] = 3'd1;   // (x=10, y=10)
        mem[1606] = 3'd0;   // (x=12, y=10)
        mem[1607] = 3'd3;   // (x=14, y=10)
        overlay_en = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset oe", 32'(oe), 0);
        check("reset r_addr", 32'(r_addr), 0);
        check("reset de_o", 32'(de_o), 0);
        check("reset vsync_o", 32'(vsync_o), 0);
        check("reset rgb_o", 32'(rgb_o), 0);
`ifdef LABEL_HIST_EN
        check("reset hist_valid", 32'(hist_valid), 0);
        check("reset hist_cnt", 32'(hist_cnt), 0);
`endif
        rst_n = 1'b1;
        idle(2);

        // Address map
        step(1'b1, 639, 479, 12'h123, 1'b0);
        check("addr corner oe", 32'(oe), 1);
        check("addr corner r_addr", 32'(r_addr), 76799);
        step(1'b1, 2, 3, 12'h456, 1'b0);
        check("addr 2,3 r_addr", 32'(r_addr), 321);
        step(1'b0, 0, 0, 12'h000, 1'b0);
        check("addr blank oe", 32'(oe), 0);
        check("addr blank r_addr hold", 32'(r_addr), 321);
        idle(3);

        // Blend: label 1 over 0x888
        step(1'b1, 10, 10, 12'h888, 1'b0);
        idle(2);
        check("blend road de_o", 32'(de_o), 1);
        check("blend road rgb_o", 32'(rgb_o), 32'h0B44);
        // Same pixel with overlay disabled at the output stage
        step(1'b1, 10, 10, 12'h888, 1'b0);
        idle(1);
        overlay_en = 1'b0;
        idle(1);
        check("blend overlay off", 32'(rgb_o), 32'h0888);
        overlay_en = 1'b1;
        // Label 0 passes through
        step(1'b1, 12, 10, 12'h888, 1'b0);
        idle(2);
        check("blend label0", 32'(rgb_o), 32'h0888);
        // Label 3 (vehicle, blue)
        step(1'b1, 14, 10, 12'h888, 1'b0);
        idle(2);
        check("blend vehicle", 32'(rgb_o), 32'h044B);
        // overlay_en change takes effect on the very next output pixel
        step(1'b1, 10, 10, 12'h888, 1'b0);
        step(1'b1, 10, 10, 12'h888, 1'b0);
        step(1'b0, 0, 0, 12'h000, 1'b0);
        check("overlay toggle first", 32'(rgb_o), 32'h0B44);
        overlay_en = 1'b0;
        idle(1);
        check("overlay toggle second", 32'(rgb_o), 32'h0888);
        overlay_en = 1'b1;
        // Out-of-range column with de_i high: no read, pass-through
        step(1'b1, 700, 10, 12'h5A5, 1'b0);
        check("range oe", 32'(oe), 0);
        idle(2);
        check("range de_o", 32'(de_o), 1);
        check("range rgb_o", 32'(rgb_o), 32'h05A5);

        // Blanking
        step(1'b0, 0, 0, 12'hFFF, 1'b0);
        idle(2);
        check("blank de_o", 32'(de_o), 0);
        check("blank rgb_o", 32'(rgb_o), 0);

        // vsync delay of exactly 3 cycles
        step(1'b0, 0, 0, 12'h000, 1'b1);
        check("vsync +1", 32'(vsync_o), 0);
        idle(1);
        check("vsync +2", 32'(vsync_o), 0);
        idle(1);
        check("vsync +3", 32'(vsync_o), 1);
        idle(1);
        check("vsync +4", 32'(vsync_o), 0);

        // Sweep across the bottom-right raster boundary with overlay toggling
        for (int y = 476; y < 482; y++) begin
            for (int x = 634; x < 644; x++) begin
                overlay_en = ((x + y) % 3) != 0;
                step(1'b1, x, y, 12'(x * 7 + y * 13), 1'b0);
            end
        end
        overlay_en = 1'b1;
        idle(4);

`ifdef LABEL_HIST_EN
        // Memory: label 2 everywhere except 100 entries of label 5
        for (int a = 0; a < MEM_N; a++) mem[a] = 3'd2;
        for (int i = 0; i < 100; i++) mem[i * 768] = 3'd5;

        // Partial frame, then reset at line 200
        for (int x = 0; x < 640; x += 2) step(1'b1, x, 200, 12'h000, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midreset oe", 32'(oe), 0);
        check("midreset r_addr", 32'(r_addr), 0);
        check("midreset de_o", 32'(de_o), 0);
        check("midreset rgb_o", 32'(rgb_o), 0);
        check("midreset hist_valid", 32'(hist_valid), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("release vsync_o", 32'(vsync_o), 0);
        check("release hist_cnt", 32'(hist_cnt), 0);

        // First edge after reset arms the counters, no snapshot
        hv_before = hv_count;
        step(1'b0, 0, 0, 12'h000, 1'b1);
        idle(6);
        check("discard edge hist_valid count", 32'(hv_count - hv_before), 0);

        // One full frame: every sampled pixel once
        for (int y = 0; y < 480; y += 2) begin
            for (int x = 0; x < 640; x += 2) step(1'b1, x, y, 12'h000, 1'b0);
        end
        idle(3);
        hv_before = hv_count;
        step(1'b0, 0, 0, 12'h000, 1'b1);
        idle(6);
        check("frame hist_valid count", 32'(hv_count - hv_before), 1);
        sum = 0;
        for (int s = 0; s < 8; s++) begin
            hist_sel = 3'(s);
            #1;
            sum += int'(hist_cnt);
            if (s == 2)      check("hist bin 2", 32'(hist_cnt), 76700);
            else if (s == 5) check("hist bin 5", 32'(hist_cnt), 100);
            else             check("hist other bin", 32'(hist_cnt), 0);
        end
        check("hist sum", 32'(sum), 76800);

        // Sample on the same cycle as the vsync edge goes to the new frame
        mem[642] = 3'd3;    // (x=4, y=4)
        mem[643] = 3'd3;    // (x=6, y=4)
        step(1'b1, 6, 4, 12'h000, 1'b0);
        idle(3);
        step(1'b1, 4, 4, 12'h000, 1'b0);
        step(1'b0, 0, 0, 12'h000, 1'b0);
        step(1'b0, 0, 0, 12'h000, 1'b1);
        idle(4);
        hist_sel = 3'd3;
        #1;
        check("edge snapshot bin 3", 32'(hist_cnt), 1);
        hist_sel = 3'd2;
        #1;
        check("edge snapshot bin 2", 32'(hist_cnt), 0);
        step(1'b0, 0, 0, 12'h000, 1'b1);
        idle(4);
        hist_sel = 3'd3;
        #1;
        check("carried bin 3", 32'(hist_cnt), 1);
        hist_sel = 3'd5;
        #1;
        check("carried bin 5", 32'(hist_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_label_overlay_reader
